pc_unit: RTL and testbench

Program counter for the multi-cycle MIPS-subset CPU core. Holds the address of the instruction currently being fetched and executed, and advances it once per instruction. Implements jumps and conditional branches with one architectural branch delay slot, generates the link request for linking branches and jumps, and flags halt when execution reaches address 0. It sits between the decoder/ALU flag outputs and the instruction-memory address port.

---
 rtl/pc_unit_if.sv | 30 +++
 rtl/pc_unit.sv | 101 ++++++++++
 tb/tb_pc_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// pc_unit_if: bus between the CPU control/decode logic and the program counter.
// The master (CPU control) drives state strobes, decoded fields and ALU flags;
// the slave (pc_unit) returns the fetch address, link request and halt.
interface pc_unit_if;
  logic        fetch;
  logic        exec1;
  logic        exec2;
  logic [6:0]  internal_code;
  logic [15:0] offset;
  logic [25:0] instr_index;
  logic [31:0] register_data;
  logic        zero;
  logic        positive;
  logic        negative;
  logic [31:0] address;
  logic        link;
  logic        halt;

  modport master (
    output fetch, exec1, exec2, internal_code, offset, instr_index,
           register_data, zero, positive, negative,
    input  address, link, halt
  );

  modport slave (
    input  fetch, exec1, exec2, internal_code, offset, instr_index,
           register_data, zero, positive, negative,
    output address, link, halt
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter for the multi-cycle MIPS-subset core.
// One architectural branch delay slot via a single-entry pending-target
// register; halts when the PC is loaded with 0.
// Optional build macro: PC_ALIGN_CHECK_EN -- a misaligned taken target halts
// the core instead of being loaded.
module pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input logic   clk,
  input logic   reset,
  pc_unit_if.slave bus
);
  localparam logic [6:0] C_BEQ    = 7'd30;
  localparam logic [6:0] C_BGEZ   = 7'd31;
  localparam logic [6:0] C_BGEZAL = 7'd32;
  localparam logic [6:0] C_BGTZ   = 7'd33;
  localparam logic [6:0] C_BLEZ   = 7'd34;
  localparam logic [6:0] C_BLTZ   = 7'd35;
  localparam logic [6:0] C_BLTZAL = 7'd36;
  localparam logic [6:0] C_BNE    = 7'd37;
  localparam logic [6:0] C_J      = 7'd38;
  localparam logic [6:0] C_JAL    = 7'd39;
  localparam logic [6:0] C_JALR   = 7'd40;
  localparam logic [6:0] C_JR     = 7'd41;

  logic [31:0] pc;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic        halted;

  logic        taken;
  logic [31:0] target;
  logic        link;
  logic [31:0] pc_inc;
  logic [31:0] br_target;
  logic        step;

  assign pc_inc    = pc + 32'd4;
  assign br_target = pc + {{14{bus.offset[15]}}, bus.offset, 2'b00};
  // Only the last execute cycle advances the PC; fetch/exec1 edges are idle.
  assign step      = bus.exec2 && !bus.fetch && !bus.exec1 && !halted;

  // Decode: taken condition, target and link request for the current code.
  always_comb begin
    taken  = 1'b0;
    target = br_target;
    link   = 1'b0;
    case (bus.internal_code)
      C_BEQ:    taken = bus.zero;
      C_BGEZ:   taken = bus.zero | bus.positive;
      C_BGEZAL: begin taken = bus.zero | bus.positive; link = 1'b1; end
      C_BGTZ:   taken = bus.positive;
      C_BLEZ:   taken = bus.zero | bus.negative;
      C_BLTZ:   taken = bus.negative;
      C_BLTZAL: begin taken = bus.negative; link = 1'b1; end
      C_BNE:    taken = !bus.zero;
      C_J:      begin taken = 1'b1; target = {pc[31:28], bus.instr_index, 2'b00}; end
      C_JAL:    begin taken = 1'b1; target = {pc[31:28], bus.instr_index, 2'b00}; link = 1'b1; end
      C_JALR:   begin taken = 1'b1; target = bus.register_data; link = 1'b1; end
      C_JR:     begin taken = 1'b1; target = bus.register_data; end
      default:  taken = 1'b0;
    endcase
  end

  // PC / delay-slot state: a pending target always beats the current code,
  // so a jump sitting in a delay slot is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_VECTOR;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      halted      <= 1'b0;
    end else if (step) begin
      if (pend_valid) begin
        pend_valid <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        if (pend_target[1:0] != 2'b00) begin
          halted <= 1'b1;
        end else begin
          pc <= pend_target;
          if (pend_target == 32'd0) halted <= 1'b1;
        end
`else
        pc <= pend_target;
        if (pend_target == 32'd0) halted <= 1'b1;
`endif
      end else begin
        pc <= pc_inc;
        if (pc_inc == 32'd0) halted <= 1'b1;
        if (taken) begin
          pend_valid  <= 1'b1;
          pend_target <= target;
        end
      end
    end
  end

  assign bus.address = pc;
  assign bus.link    = link;
  assign bus.halt    = halted;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors for pc_unit with hand-computed addresses.
module tb_pc_unit;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  pc_unit_if bus ();

  pc_unit #(.RESET_VECTOR(32'hBFC0_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One instruction: fetch, exec1, exec2. Inputs change at negedge and
  // outputs are sampled there, away from the rising edge.
  task automatic instr(input logic [6:0] code, input logic [15:0] off,
                       input logic [25:0] idx, input logic [31:0] rd,
                       input logic z, input logic p, input logic n,
                       input logic [31:0] exp_addr, input logic exp_link,
                       input string tag);
    @(negedge clk);
    bus.internal_code = code; bus.offset = off; bus.instr_index = idx;
    bus.register_data = rd; bus.zero = z; bus.positive = p; bus.negative = n;
    bus.fetch = 1'b1; bus.exec1 = 1'b0; bus.exec2 = 1'b0;
    #1;
    chk({tag, ".addr"}, bus.address, exp_addr);
    chk({tag, ".link"}, {31'd0, bus.link}, {31'd0, exp_link});
    @(negedge clk);
    bus.fetch = 1'b0; bus.exec1 = 1'b1;
    @(negedge clk);
    bus.exec1 = 1'b0; bus.exec2 = 1'b1;
    #1;
    chk({tag, ".stable"}, bus.address, exp_addr);
    @(negedge clk);
    bus.exec2 = 1'b0;
  endtask

  task automatic nop(input logic [31:0] exp_addr, input string tag);
    instr(7'd1, 16'd0, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0, exp_addr, 1'b0, tag);
  endtask

  logic [6:0]  codes [7];
  logic [2:0]  sat   [7];
  logic [2:0]  vio   [7];
  logic        lnk   [7];
  logic [31:0] x;

  initial begin
    total = 0; bad = 0;
    codes = '{7'd31, 7'd32, 7'd33, 7'd34, 7'd35, 7'd36, 7'd37};
    // flags as {zero, positive, negative}
    sat   = '{3'b010, 3'b100, 3'b010, 3'b001, 3'b001, 3'b001, 3'b010};
    vio   = '{3'b001, 3'b001, 3'b100, 3'b010, 3'b010, 3'b100, 3'b100};
    lnk   = '{1'b0,   1'b1,   1'b0,   1'b0,   1'b0,   1'b1,   1'b0};

    bus.fetch = 0; bus.exec1 = 0; bus.exec2 = 0;
    bus.internal_code = 7'd1; bus.offset = 0; bus.instr_index = 0;
    bus.register_data = 0; bus.zero = 0; bus.positive = 0; bus.negative = 0;
    reset = 1'b1;
    #12;
    chk("rst.addr", bus.address, 32'hBFC0_0000);
    chk("rst.halt", {31'd0, bus.halt}, 32'd0);
    reset = 1'b0;

    nop(32'hBFC0_0000, "seq0");
    nop(32'hBFC0_0004, "seq1");
    instr(7'd41, 16'd0, 26'd0, 32'd4, 0, 0, 0, 32'hBFC0_0008, 1'b0, "jr");
    nop(32'hBFC0_000C, "jr.slot");
    instr(7'd38, 16'd0, 26'd25000, 32'd0, 0, 0, 0, 32'd4, 1'b0, "j");
    nop(32'd8, "j.slot");
    nop(32'd100000, "j.tgt");
    instr(7'd39, 16'd0, 26'd50000, 32'd0, 0, 0, 0, 32'd100004, 1'b1, "jal");
    nop(32'd100008, "jal.slot");
    nop(32'd200000, "jal.tgt");
    nop(32'd200004, "seq2");
    nop(32'd200008, "seq3");
    instr(7'd30, 16'd25000, 26'd0, 32'd0, 1, 0, 0, 32'd200012, 1'b0, "beq.t");
    nop(32'd200016, "beq.slot");
    instr(7'd30, 16'd25000, 26'd0, 32'd0, 0, 1, 0, 32'd300012, 1'b0, "beq.nt");
    nop(32'd300016, "beq.nt.slot");
    // JR inside a delay slot must not override the pending target
    instr(7'd38, 16'd0, 26'd1000, 32'd0, 0, 0, 0, 32'd300020, 1'b0, "j2");
    instr(7'd41, 16'd0, 26'd0, 32'd64, 0, 0, 0, 32'd300024, 1'b0, "j2.slot.jr");
    nop(32'd4000, "j2.tgt");
    nop(32'd4004, "seq4");
    x = 32'd4008;

    for (int i = 0; i < 7; i++) begin
      instr(codes[i], 16'd25000, 26'd0, 32'd0, sat[i][2], sat[i][1], sat[i][0],
            x, lnk[i], $sformatf("br%0d.t", codes[i]));
      nop(x + 32'd4, $sformatf("br%0d.t.slot", codes[i]));
      x = x + 32'd100000;
      instr(codes[i], 16'd25000, 26'd0, 32'd0, vio[i][2], vio[i][1], vio[i][0],
            x, lnk[i], $sformatf("br%0d.nt", codes[i]));
      nop(x + 32'd4, $sformatf("br%0d.nt.slot", codes[i]));
      x = x + 32'd8;
    end

    // negative offset: -4 words
    instr(7'd30, 16'hFFFC, 26'd0, 32'd0, 1, 0, 0, x, 1'b0, "beq.neg");
    nop(x + 32'd4, "beq.neg.slot");
    x = x - 32'd16;

    instr(7'd41, 16'd0, 26'd0, 32'd0, 0, 0, 0, x, 1'b0, "jr0");
    chk("jr0.halt.pre", {31'd0, bus.halt}, 32'd0);
    nop(x + 32'd4, "jr0.slot");
    chk("halt.set", {31'd0, bus.halt}, 32'd1);
    for (int i = 0; i < 10; i++) nop(32'd0, $sformatf("frozen%0d", i));
    instr(7'd41, 16'd0, 26'd0, 32'd64, 0, 0, 0, 32'd0, 1'b0, "frozen.jr");
    nop(32'd0, "frozen.after.jr");
    chk("halt.hold", {31'd0, bus.halt}, 32'd1);

    #2 reset = 1'b1;
    #1;
    chk("rst2.addr", bus.address, 32'hBFC0_0000);
    chk("rst2.halt", {31'd0, bus.halt}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    nop(32'hBFC0_0000, "post0");
    nop(32'hBFC0_0004, "post1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
